// File: rtl/register_mp_pkg.sv
// rtl/register_mp_pkg.sv - shared widths, port counts and constants for the multi-ported register file
package register_mp_pkg;
    localparam int DEF_DWIDTH = 32;
    localparam int DEF_AWIDTH = 5;
    localparam int DEF_NREG   = 32;
    localparam int DEF_NISS   = 2;
    localparam int DEF_NWR    = 2;
    localparam int REG_ZERO   = 0;
endpackage

// File: rtl/register_rdport.sv
// rtl/register_rdport.sv - one combinational read port: zero/range check and write-back bypass mux
module register_rdport
    import register_mp_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int NREG   = DEF_NREG,
    parameter int NWR    = DEF_NWR
) (
    input  logic                   rst,
    input  logic [AWIDTH-1:0]      addr,
    input  logic [NREG*DWIDTH-1:0] regs_flat,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*AWIDTH-1:0]  wr_addr,
    input  logic [NWR*DWIDTH-1:0]  wr_data,
    output logic [DWIDTH-1:0]      data
);

    logic in_range;
    assign in_range = (int'(addr) < NREG);

    always_comb begin
        data = '0;
        for (int r = 0; r < NREG; r++) begin
            if (addr == AWIDTH'(r))
                data = regs_flat[r*DWIDTH +: DWIDTH];
        end
        // later ports override earlier ones: the highest-index writer is the youngest
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && in_range && wr_addr[k*AWIDTH +: AWIDTH] == addr)
                data = wr_data[k*DWIDTH +: DWIDTH];
        end
        if (rst || !in_range || addr == AWIDTH'(REG_ZERO))
            data = '0;
    end

endmodule

// File: rtl/register_mp.sv
// rtl/register_mp.sv - NISS-lane read / NWR-port write register file with busy scoreboard
module register_mp
    import register_mp_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int NREG   = DEF_NREG,
    parameter int NISS   = DEF_NISS,
    parameter int NWR    = DEF_NWR
) (
    input  logic                   r_clk,
    input  logic                   r_rst,
    input  logic [NWR-1:0]         r_wr_en,
    input  logic [NWR*AWIDTH-1:0]  r_i_addr_rd,
    input  logic [NWR*DWIDTH-1:0]  r_i_data_rd,
    input  logic [NISS*AWIDTH-1:0] r_i_addr_rs,
    input  logic [NISS*AWIDTH-1:0] r_i_addr_rt,
    output logic [NISS*DWIDTH-1:0] r_o_data_rs,
    output logic [NISS*DWIDTH-1:0] r_o_data_rt,
    input  logic [NISS-1:0]        r_i_alloc_en,
    input  logic [NISS*AWIDTH-1:0] r_i_alloc_addr,
    output logic [NISS-1:0]        r_o_rs_busy,
    output logic [NISS-1:0]        r_o_rt_busy
);

    logic [DWIDTH-1:0]      regs [NREG];
    logic [NREG-1:0]        busy;
    logic [NREG*DWIDTH-1:0] regs_flat;

    always_comb begin
        regs_flat = '0;
        for (int r = 0; r < NREG; r++)
            regs_flat[r*DWIDTH +: DWIDTH] = regs[r];
    end

    // Register 0 and out-of-range addresses never match the loops, so they are dropped.
    // Allocations come after writes so a same-cycle set supersedes the clear.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                for (int r = REG_ZERO + 1; r < NREG; r++) begin
                    if (r_wr_en[k] && r_i_addr_rd[k*AWIDTH +: AWIDTH] == AWIDTH'(r)) begin
                        regs[r] <= r_i_data_rd[k*DWIDTH +: DWIDTH];
                        busy[r] <= 1'b0;
                    end
                end
            end
            for (int l = 0; l < NISS; l++) begin
                for (int r = REG_ZERO + 1; r < NREG; r++) begin
                    if (r_i_alloc_en[l] && r_i_alloc_addr[l*AWIDTH +: AWIDTH] == AWIDTH'(r))
                        busy[r] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        r_o_rs_busy = '0;
        r_o_rt_busy = '0;
        for (int l = 0; l < NISS; l++) begin
            for (int r = 0; r < NREG; r++) begin
                if (r_i_addr_rs[l*AWIDTH +: AWIDTH] == AWIDTH'(r))
                    r_o_rs_busy[l] = busy[r];
                if (r_i_addr_rt[l*AWIDTH +: AWIDTH] == AWIDTH'(r))
                    r_o_rt_busy[l] = busy[r];
            end
        end
    end

    for (genvar l = 0; l < NISS; l++) begin : g_lane
        register_rdport #(
            .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NREG(NREG), .NWR(NWR)
        ) u_rs (
            .rst       (r_rst),
            .addr      (r_i_addr_rs[l*AWIDTH +: AWIDTH]),
            .regs_flat (regs_flat),
            .wr_en     (r_wr_en),
            .wr_addr   (r_i_addr_rd),
            .wr_data   (r_i_data_rd),
            .data      (r_o_data_rs[l*DWIDTH +: DWIDTH])
        );
        register_rdport #(
            .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NREG(NREG), .NWR(NWR)
        ) u_rt (
            .rst       (r_rst),
            .addr      (r_i_addr_rt[l*AWIDTH +: AWIDTH]),
            .regs_flat (regs_flat),
            .wr_en     (r_wr_en),
            .wr_addr   (r_i_addr_rd),
            .wr_data   (r_i_data_rd),
            .data      (r_o_data_rt[l*DWIDTH +: DWIDTH])
        );
    end

endmodule

// File: tb/tb_register_mp.sv
// tb/tb_register_mp.sv - randomized and directed bench for register_mp (NREG=32 and NREG=16 instances)
module tb_register_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NI = 2;
    localparam int NW = 2;

    logic          r_clk = 1'b0;
    logic          r_rst = 1'b1;
    logic [NW-1:0]    wr_en = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*DW-1:0] wr_data = '0;
    logic [NI*AW-1:0] rs_addr = '0;
    logic [NI*AW-1:0] rt_addr = '0;
    logic [NI-1:0]    al_en = '0;
    logic [NI*AW-1:0] al_addr = '0;
    logic [NI*DW-1:0] o_rs [2];
    logic [NI*DW-1:0] o_rt [2];
    logic [NI-1:0]    o_rsb [2];
    logic [NI-1:0]    o_rtb [2];

    int n_cmp = 0;
    int n_fail = 0;
    int nreg [2] = '{32, 16};
    logic [31:0] mem [2][32];
    bit          bsy [2][32];

    always #5 r_clk = ~r_clk;

    register_mp #(.DWIDTH(DW), .AWIDTH(AW), .NREG(32), .NISS(NI), .NWR(NW)) dut (
        .r_clk(r_clk), .r_rst(r_rst), .r_wr_en(wr_en), .r_i_addr_rd(wr_addr),
        .r_i_data_rd(wr_data), .r_i_addr_rs(rs_addr), .r_i_addr_rt(rt_addr),
        .r_o_data_rs(o_rs[0]), .r_o_data_rt(o_rt[0]), .r_i_alloc_en(al_en),
        .r_i_alloc_addr(al_addr), .r_o_rs_busy(o_rsb[0]), .r_o_rt_busy(o_rtb[0]));

    register_mp #(.DWIDTH(DW), .AWIDTH(AW), .NREG(16), .NISS(NI), .NWR(NW)) dut16 (
        .r_clk(r_clk), .r_rst(r_rst), .r_wr_en(wr_en), .r_i_addr_rd(wr_addr),
        .r_i_data_rd(wr_data), .r_i_addr_rs(rs_addr), .r_i_addr_rt(rt_addr),
        .r_o_data_rs(o_rs[1]), .r_o_data_rt(o_rt[1]), .r_i_alloc_en(al_en),
        .r_i_alloc_addr(al_addr), .r_o_rs_busy(o_rsb[1]), .r_o_rt_busy(o_rtb[1]));

    // Reference model: plain arrays per instance, updated once per rising edge.
    function automatic logic [31:0] exp_rd(int d, int a);
        if (r_rst || a == 0 || a >= nreg[d]) return 32'h0;
        for (int k = NW - 1; k >= 0; k--)
            if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) return wr_data[k*DW +: DW];
        return mem[d][a];
    endfunction

    function automatic bit exp_busy(int d, int a);
        if (r_rst || a == 0 || a >= nreg[d]) return 1'b0;
        return bsy[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 32; a++) begin
                mem[d][a] = '0;
                bsy[d][a] = 1'b0;
            end
    endtask

    task automatic commit();
        if (!r_rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NW; k++) begin
                    int a = int'(wr_addr[k*AW +: AW]);
                    if (wr_en[k] && a != 0 && a < nreg[d]) begin
                        mem[d][a] = wr_data[k*DW +: DW];
                        bsy[d][a] = 1'b0;
                    end
                end
                for (int l = 0; l < NI; l++) begin
                    int a = int'(al_addr[l*AW +: AW]);
                    if (al_en[l] && a != 0 && a < nreg[d]) bsy[d][a] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        commit();
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0; al_en = '0; al_addr = '0;
    endtask

    task automatic set_wr(int k, logic [AW-1:0] a, logic [DW-1:0] v);
        wr_en[k] = 1'b1;
        wr_addr[k*AW +: AW] = a;
        wr_data[k*DW +: DW] = v;
    endtask

    task automatic set_alloc(int l, logic [AW-1:0] a);
        al_en[l] = 1'b1;
        al_addr[l*AW +: AW] = a;
    endtask

    task automatic set_reads(logic [AW-1:0] a);
        for (int l = 0; l < NI; l++) begin
            rs_addr[l*AW +: AW] = a;
            rt_addr[l*AW +: AW] = a;
        end
    endtask

    task automatic random_cycles(int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < NW; k++) begin
                wr_en[k] = 1'($urandom_range(0, 1));
                wr_addr[k*AW +: AW] = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
                wr_data[k*DW +: DW] = $urandom;
            end
            for (int l = 0; l < NI; l++) begin
                al_en[l] = ($urandom_range(0, 3) == 0);
                al_addr[l*AW +: AW] = AW'($urandom_range(0, 31));
                rs_addr[l*AW +: AW] = AW'($urandom_range(0, 31));
                rt_addr[l*AW +: AW] = AW'($urandom_range(0, 31));
            end
            #1;
            for (int d = 0; d < 2; d++)
                for (int l = 0; l < NI; l++) begin
                    int ars = int'(rs_addr[l*AW +: AW]);
                    int art = int'(rt_addr[l*AW +: AW]);
                    n_cmp += 4;
                    if (o_rs[d][l*DW +: DW] !== exp_rd(d, ars)) begin
                        n_fail++; $display("FAIL rand_rs d%0d l%0d a%0d got %h want %h", d, l, ars, o_rs[d][l*DW +: DW], exp_rd(d, ars));
                    end
                    if (o_rt[d][l*DW +: DW] !== exp_rd(d, art)) begin
                        n_fail++; $display("FAIL rand_rt d%0d l%0d a%0d got %h want %h", d, l, art, o_rt[d][l*DW +: DW], exp_rd(d, art));
                    end
                    if (o_rsb[d][l] !== exp_busy(d, ars)) begin
                        n_fail++; $display("FAIL rand_rs_busy d%0d l%0d a%0d got %b want %b", d, l, ars, o_rsb[d][l], exp_busy(d, ars));
                    end
                    if (o_rtb[d][l] !== exp_busy(d, art)) begin
                        n_fail++; $display("FAIL rand_rt_busy d%0d l%0d a%0d got %b want %b", d, l, art, o_rtb[d][l], exp_busy(d, art));
                    end
                end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        set_wr(1, 5'd3, 32'h1234_5678);
        set_reads(5'd3);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp += 2;
            if (o_rs[d] !== '0 || o_rt[d] !== '0) begin
                n_fail++; $display("FAIL reset_hold_data d%0d got %h/%h want 0", d, o_rs[d], o_rt[d]);
            end
            if (o_rsb[d] !== '0 || o_rtb[d] !== '0) begin
                n_fail++; $display("FAIL reset_hold_busy d%0d got %b/%b want 0", d, o_rsb[d], o_rtb[d]);
            end
        end
        tick();
        clear_inputs();
        #2 r_rst = 1'b0;
        random_cycles(20);
        #2 r_rst = 1'b1;
        model_reset();
        tick(); tick();
        #2 r_rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            set_reads(AW'(a));
            #1;
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_rs[d] !== '0 || o_rt[d] !== '0 || o_rsb[d] !== '0 || o_rtb[d] !== '0) begin
                    n_fail++; $display("FAIL reset_sweep d%0d a%0d got %h/%h busy %b/%b want 0", d, a, o_rs[d], o_rt[d], o_rsb[d], o_rtb[d]);
                end
            end
        end
    endtask

    task automatic test_fill();
        for (int j = 0; j < 16; j++) begin
            clear_inputs();
            if (j < 15) set_wr(0, AW'(j + 1), 32'(j + 1));
            set_wr(1, AW'(16 + j), 32'(116 + j));
            tick();
        end
        clear_inputs();
        for (int a = 0; a < 32; a++) begin
            logic [31:0] want [2];
            want[0] = (a == 0) ? 32'h0 : (a < 16) ? 32'(a) : 32'(a + 100);
            want[1] = (a == 0 || a >= 16) ? 32'h0 : 32'(a);
            set_reads(AW'(a));
            #1;
            for (int d = 0; d < 2; d++)
                for (int l = 0; l < NI; l++) begin
                    n_cmp += 2;
                    if (o_rs[d][l*DW +: DW] !== want[d]) begin
                        n_fail++; $display("FAIL fill_rs d%0d l%0d a%0d got %h want %h", d, l, a, o_rs[d][l*DW +: DW], want[d]);
                    end
                    if (o_rt[d][l*DW +: DW] !== want[d]) begin
                        n_fail++; $display("FAIL fill_rt d%0d l%0d a%0d got %h want %h", d, l, a, o_rt[d][l*DW +: DW], want[d]);
                    end
                end
        end
    endtask

    task automatic test_reg0();
        set_wr(0, 5'd0, 32'hDEAD_BEEF);
        set_wr(1, 5'd0, 32'hDEAD_BEEF);
        set_alloc(0, 5'd0);
        set_alloc(1, 5'd0);
        set_reads(5'd0);
        #1;
        n_cmp++;
        if (o_rs[0][31:0] !== 32'h0) begin
            n_fail++; $display("FAIL reg0_bypass got %h want 0", o_rs[0][31:0]);
        end
        tick();
        clear_inputs();
        #1;
        n_cmp += 2;
        if (o_rs[0][31:0] !== 32'h0 || o_rt[0][63:32] !== 32'h0) begin
            n_fail++; $display("FAIL reg0_data got %h/%h want 0", o_rs[0][31:0], o_rt[0][63:32]);
        end
        if (o_rsb[0] !== 2'b00 || o_rtb[1] !== 2'b00) begin
            n_fail++; $display("FAIL reg0_busy got %b/%b want 00", o_rsb[0], o_rtb[1]);
        end
    endtask

    task automatic test_bypass();
        set_wr(0, 5'd5, 32'h11);
        set_wr(1, 5'd5, 32'h22);
        set_reads(5'd5);
        rt_addr[0 +: AW] = 5'd7;
        #1;
        n_cmp++;
        if (o_rs[0][31:0] !== 32'h22) begin
            n_fail++; $display("FAIL collide_bypass got %h want 22", o_rs[0][31:0]);
        end
        tick();
        clear_inputs();
        set_wr(0, 5'd7, 32'h33);
        #1;
        n_cmp += 2;
        if (o_rs[0][31:0] !== 32'h22) begin
            n_fail++; $display("FAIL collide_stored got %h want 22", o_rs[0][31:0]);
        end
        if (o_rt[0][31:0] !== 32'h33) begin
            n_fail++; $display("FAIL single_bypass got %h want 33", o_rt[0][31:0]);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        set_reads(5'd9);
        set_alloc(0, 5'd9);
        #1;
        n_cmp++;
        if (o_rsb[0] !== 2'b00) begin
            n_fail++; $display("FAIL sb_before got %b want 00", o_rsb[0]);
        end
        tick();
        clear_inputs();
        n_cmp++;
        if (o_rsb[0][1] !== 1'b1 || o_rsb[1][1] !== 1'b1) begin
            n_fail++; $display("FAIL sb_alloc got %b/%b want 1/1", o_rsb[0][1], o_rsb[1][1]);
        end
        set_wr(1, 5'd9, 32'h9A);
        #1;
        n_cmp++;
        if (o_rtb[0][0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_no_bypass got %b want 1", o_rtb[0][0]);
        end
        tick();
        clear_inputs();
        n_cmp++;
        if (o_rsb[0] !== 2'b00 || o_rtb[0] !== 2'b00) begin
            n_fail++; $display("FAIL sb_clear got %b/%b want 00", o_rsb[0], o_rtb[0]);
        end
        set_alloc(1, 5'd9);
        set_alloc(0, 5'd9);
        set_wr(0, 5'd9, 32'h99);
        tick();
        clear_inputs();
        n_cmp += 2;
        if (o_rsb[0] !== 2'b11 || o_rtb[1] !== 2'b11) begin
            n_fail++; $display("FAIL sb_set_wins got %b/%b want 11", o_rsb[0], o_rtb[1]);
        end
        if (o_rs[0][63:32] !== 32'h99) begin
            n_fail++; $display("FAIL sb_set_data got %h want 99", o_rs[0][63:32]);
        end
    endtask

    task automatic test_out_of_range();
        set_wr(0, 5'd20, 32'h55);
        set_alloc(1, 5'd20);
        tick();
        clear_inputs();
        set_reads(5'd20);
        #1;
        n_cmp += 3;
        if (o_rs[1] !== '0 || o_rt[1] !== '0) begin
            n_fail++; $display("FAIL oor_read got %h/%h want 0", o_rs[1], o_rt[1]);
        end
        if (o_rsb[1] !== '0) begin
            n_fail++; $display("FAIL oor_busy got %b want 00", o_rsb[1]);
        end
        if (o_rs[0][31:0] !== 32'h55) begin
            n_fail++; $display("FAIL oor_wide_inst got %h want 55", o_rs[0][31:0]);
        end
        for (int a = 1; a < 16; a++) begin
            set_reads(AW'(a));
            #1;
            n_cmp++;
            if (o_rs[1][31:0] !== exp_rd(1, a)) begin
                n_fail++; $display("FAIL oor_corrupt a%0d got %h want %h", a, o_rs[1][31:0], exp_rd(1, a));
            end
        end
    endtask

    task automatic test_async_reset();
        set_wr(0, 5'd4, 32'hAAAA);
        set_alloc(0, 5'd6);
        rs_addr = {5'd4, 5'd2};
        rt_addr = {5'd6, 5'd3};
        tick();
        set_wr(1, 5'd2, 32'hBBBB);
        #2;
        r_rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp += 2;
            if (o_rs[d] !== '0 || o_rt[d] !== '0) begin
                n_fail++; $display("FAIL async_reset_data d%0d got %h/%h want 0", d, o_rs[d], o_rt[d]);
            end
            if (o_rsb[d] !== '0 || o_rtb[d] !== '0) begin
                n_fail++; $display("FAIL async_reset_busy d%0d got %b/%b want 0", d, o_rsb[d], o_rtb[d]);
            end
        end
        tick();
        clear_inputs();
        #2 r_rst = 1'b0;
        #1;
        n_cmp++;
        if (o_rs[0] !== '0 || o_rtb[0] !== '0) begin
            n_fail++; $display("FAIL async_reset_after got %h busy %b want 0", o_rs[0], o_rtb[0]);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_reg0();
        test_bypass();
        test_scoreboard();
        test_out_of_range();
        random_cycles(300);
        test_async_reset();
        random_cycles(100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/register_mp.md
Name: register_mp

Overview:
- Multi-ported architectural register file for the dual-issue MIPS core; successor of the single-issue 2R/1W register file.
- Provides NISS read-port pairs (rs/rt) and NWR write-back ports, with same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard, set at issue and cleared at write-back, so the issue stage can detect RAW hazards.
- Sits between decode/issue (reads, allocations) and the write-back stage (writes).

Parameters:
- DWIDTH, 32, data width of each register (default taken from the shared `DWIDTH).
- AWIDTH, 5, register address width (default taken from the shared `AWIDTH).
- NREG, 32, number of registers; must be ≤ 2**AWIDTH.
- NISS, 2, issue lanes; each lane has one rs/rt read pair and one allocation port.
- NWR, 2, write-back ports.

Ports:
- r_clk  input  1  clock; all state updates on the rising edge.
- r_rst  input  1  reset, asynchronous, active-high.
- r_wr_en  input  NWR  per-port write enable.
- r_i_addr_rd  input  NWR*AWIDTH  write addresses; port k occupies bits [k*AWIDTH +: AWIDTH].
- r_i_data_rd  input  NWR*DWIDTH  write data, packed the same way.
- r_i_addr_rs  input  NISS*AWIDTH  rs read addresses, one per lane.
- r_i_addr_rt  input  NISS*AWIDTH  rt read addresses, one per lane.
- r_o_data_rs  output  NISS*DWIDTH  rs read data.
- r_o_data_rt  output  NISS*DWIDTH  rt read data.
- r_i_alloc_en  input  NISS  per lane: mark the destination register busy.
- r_i_alloc_addr  input  NISS*AWIDTH  per-lane destination address.
- r_o_rs_busy  output  NISS  busy bit of each lane's rs register (combinational).
- r_o_rt_busy  output  NISS  busy bit of each lane's rt register (combinational).

Behaviour:
- Reset, asserted at any time including mid-write: all NREG registers clear to 0 and all busy bits clear to 0, immediately and asynchronously. While reset is held, every data output is 0 and every busy output is 0. Writes and allocations are ignored while r_rst=1.
- Write path:
  - On posedge, for each k with r_wr_en[k]=1 and a nonzero address, reg[addr_k] <= data_k.
  - Same-address collision between write ports: the highest-index port wins (it carries the younger instruction).
- Register 0:
  - Reads always return 0.
  - Writes to it are dropped.
  - Allocations to it are dropped.
  - Its busy bit always reads 0.
- Read path: combinational, zero-cycle latency. Priority for each read address A:
  - A = 0 returns 0.
  - Otherwise, if any write port has r_wr_en=1 and addr=A this cycle, the bypassed data of the highest-index matching port is returned.
  - Otherwise, reg[A] is returned.
- Addresses ≥ NREG: reads return 0, busy reads 0, and writes/allocations to them are dropped.
- Scoreboard, updated at posedge:
  - A write to A clears busy[A].
  - An allocation to A sets busy[A].
  - Allocation and write to the same A in the same cycle: set wins, because the new producer supersedes the old one.
  - Multiple lanes allocating the same A: busy is set once; no error.
- Busy outputs reflect the registered busy bits only; there is no bypass of same-cycle write-back on busy.
- No stalls and no handshake: every enabled write and allocation is accepted every cycle.

Decomposition:
- Shared package/define file:
  - `DWIDTH, `AWIDTH (existing).
  - New `NREG, `NISS, `NWR defaults.
  - Localparam REG_ZERO = 0.
- One sub-module, register_rdport: a single read port with zero-check, out-of-range check and write-port bypass priority mux. It is instantiated 2*NISS times.
- Storage, write arbitration and scoreboard stay in register_mp.

Test Plan:
- Reset: assert r_rst for 2 cycles after random writes, then read addresses 0..31 on all ports -> all data 0, all busy 0. Also assert r_rst asynchronously mid-cycle -> outputs drop to 0 before the next edge.
- Fill and readback: write port0 reg i=i for i=1..15 and port1 reg i=i+100 for i=16..31, one write per port per cycle. Then sweep rs/rt of both lanes -> reg i reads i (1..15) and i+100 (16..31); reg 0 reads 0.
- Register 0: write 0xDEADBEEF to addr 0 on both ports and allocate addr 0 -> rs=0 reads 0, busy 0.
- Collision and bypass:
  - Same cycle: port0 writes reg 5=0x11 and port1 writes reg 5=0x22, with lane0 rs=5 -> rs data 0x22 in that same cycle; reg 5 holds 0x22 afterwards.
  - Port0 alone writes reg 7=0x33 with rt=7 -> 0x33 with no delay.
- Scoreboard:
  - Alloc reg 9 -> next cycle rs_busy=1 on a lane reading 9.
  - Write reg 9 -> busy 0 next cycle.
  - Same-cycle alloc 9 and write 9 -> busy stays 1 and data updates.
- Out-of-range: with NREG=16, write addr 20=0x55 -> read addr 20 returns 0 and no 0..15 register is corrupted.
